// File: rtl/canny_nms_stage_if.sv
// canny_nms_stage_if: gradient sample stream in, suppressed magnitude stream out.
interface canny_nms_stage_if #(parameter int MAG_W = 24);
    logic             in_en;
    logic [MAG_W+1:0] in_data;
    logic             nms_en;
    logic [MAG_W-1:0] nms_mag;
    logic [1:0]       nms_dir;
    logic             frame_done;
    modport master (output in_en, in_data, input nms_en, nms_mag, nms_dir, frame_done);
    modport slave  (input in_en, in_data, output nms_en, nms_mag, nms_dir, frame_done);
endinterface

// File: rtl/canny_nms_stage.sv
// canny_nms_stage: 3x3 non-maximum suppression along the quantised gradient direction.
module canny_nms_stage #(
    parameter int IMG_W = 510,
    parameter int IMG_H = 636,
    parameter int MAG_W = 24
) (
    input logic clk,
    input logic rst_n,
    input logic start,
    canny_nms_stage_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    typedef logic [MAG_W-1:0] mag_t;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [MAG_W+1:0] lb1 [IMG_W];
    mag_t             lb2 [IMG_W];
    logic [MAG_W+1:0] rd1;
    mag_t             rd2;
    mag_t             top [3];
    mag_t             mid [3];
    mag_t             bot [3];
    logic [1:0]       dir0, dir1, d_q;
    logic             acc, col_last, row_last, v1, l1, v2, l2;
    mag_t             a, b, a_q, b_q, c_q;
    assign acc      = start && bus.in_en;
    assign col_last = col == CW'(IMG_W - 1);
    assign row_last = row == RW'(IMG_H - 1);
    assign rd1      = lb1[col];
    assign rd2      = lb2[col];
    // window column 0 is the newest sample (c), column 1 the centre (c-1), column 2 is c-2
    assign a = dir1 == 2'b00 ? top[1] : dir1 == 2'b01 ? mid[2] : dir1 == 2'b11 ? top[0] : top[2];
    assign b = dir1 == 2'b00 ? bot[1] : dir1 == 2'b01 ? mid[0] : dir1 == 2'b11 ? bot[2] : bot[0];
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col] <= bus.in_data;
            lb2[col] <= rd1[MAG_W-1:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (!start) begin
            col <= '0;
            row <= '0;
        end else if (bus.in_en) begin
            col <= col_last ? '0 : col + CW'(1);
            if (col_last) row <= row_last ? '0 : row + RW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top  <= '{default: '0};
            mid  <= '{default: '0};
            bot  <= '{default: '0};
            dir0 <= '0;
            dir1 <= '0;
        end else if (acc) begin
            top  <= '{rd2, top[0], top[1]};
            mid  <= '{rd1[MAG_W-1:0], mid[0], mid[1]};
            bot  <= '{bus.in_data[MAG_W-1:0], bot[0], bot[1]};
            dir0 <= rd1[MAG_W+1:MAG_W];
            dir1 <= dir0;
        end
    end
    // stale line-buffer rows are masked by the row>=2 gate, so only valids need clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1             <= 1'b0;
            l1             <= 1'b0;
            v2             <= 1'b0;
            l2             <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            d_q            <= '0;
            bus.nms_en     <= 1'b0;
            bus.nms_mag    <= '0;
            bus.nms_dir    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            v1             <= acc && row >= RW'(2) && col >= CW'(2);
            l1             <= acc && row_last && col_last;
            v2             <= start && v1;
            l2             <= start && v1 && l1;
            a_q            <= a;
            b_q            <= b;
            c_q            <= mid[1];
            d_q            <= dir1;
            bus.nms_en     <= start && v2;
            bus.nms_mag    <= (start && v2 && c_q >= a_q && c_q >= b_q) ? c_q : '0;
            bus.nms_dir    <= (start && v2) ? d_q : '0;
            bus.frame_done <= start && v2 && l2;
        end
    end
endmodule
